data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 tb/tb_data_mem_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM pipeline stage (master) and the
// data memory responder (slave).
interface data_mem_responder_if;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        data_valid;
  logic        stall;
  logic        proto_err;

  modport master (
    output mem_rd, mem_wr, addr, wdata,
    input  rdata, data_valid, stall, proto_err
  );

  modport slave (
    input  mem_rd, mem_wr, addr, wdata,
    output rdata, data_valid, stall, proto_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: latches one request, counts out the
// access latency, stalls the MEM stage meanwhile and pulses data_valid on completion.
module data_mem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int CNT_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lat_rd_q, lat_wr_q;
  logic [ADDR_W-1:0]   lat_idx_q;
  logic [15:0]         lat_wdata_q;
  logic [15:0]         rdata_q;
  logic                data_valid_q;
  logic                proto_err_q;
  logic [15:0]         mem_q [DEPTH];

  logic                req;
  logic                accept;
  logic                enter_done;
  logic                rd_only;
  logic [ADDR_W-1:0]   live_idx;
  logic [ADDR_W-1:0]   rd_idx;
  logic                read_en;
  logic                mismatch;

  assign live_idx = bus.addr[ADDR_W:1];
  assign req      = bus.mem_rd | bus.mem_wr;

  generate
    if (ADDR_W < 15) begin : g_unused_hi
      logic unused_addr_bits;
      assign unused_addr_bits = ^{bus.addr[15:ADDR_W+1], bus.addr[0]};
    end else begin : g_unused_lo
      logic unused_addr_bits;
      assign unused_addr_bits = bus.addr[0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 2);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The array read happens on the edge entering DONE so rdata is already valid
  // while data_valid is high; with LATENCY==1 that edge is the acceptance edge,
  // so the live request must be used instead of the (not yet latched) copy.
  assign enter_done = (state_d == DONE) && (state_q != DONE);
  assign rd_only    = (state_q == IDLE) ? (bus.mem_rd & ~bus.mem_wr) : (lat_rd_q & ~lat_wr_q);
  assign rd_idx     = (state_q == IDLE) ? live_idx : lat_idx_q;
  assign read_en    = enter_done & rd_only;

  assign mismatch = ((state_q == WAIT) || (state_q == DONE)) &&
                    ({bus.mem_rd, bus.mem_wr, live_idx, bus.wdata} !=
                     {lat_rd_q, lat_wr_q, lat_idx_q, lat_wdata_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lat_rd_q     <= 1'b0;
      lat_wr_q     <= 1'b0;
      lat_idx_q    <= '0;
      lat_wdata_q  <= '0;
      rdata_q      <= 16'h0000;
      data_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_valid_q <= (state_d == DONE);
      if (accept) begin
        lat_rd_q    <= bus.mem_rd;
        lat_wr_q    <= bus.mem_wr;
        lat_idx_q   <= live_idx;
        lat_wdata_q <= bus.wdata;
      end
      if (read_en)  rdata_q     <= mem_q[rd_idx];
      if (mismatch) proto_err_q <= 1'b1;
    end
  end

  // Writes commit on the edge leaving DONE; a reset before then cancels them.
  always_ff @(posedge clk) begin
    if ((state_q == DONE) && lat_wr_q) mem_q[lat_idx_q] <= lat_wdata_q;
  end

  assign bus.rdata      = rdata_q;
  assign bus.data_valid = data_valid_q;
  assign bus.stall      = req & (state_q != DONE);
  assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: DUT A runs LATENCY=4, DUT B runs LATENCY=1 (aliasing check).
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus_a ();
  data_mem_responder_if bus_b ();

  data_mem_responder #(.LATENCY(4), .ADDR_W(10)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  data_mem_responder #(.LATENCY(1), .ADDR_W(10)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] wd);
    if (sel == 0) begin
      bus_a.mem_rd = rd; bus_a.mem_wr = wr; bus_a.addr = a; bus_a.wdata = wd;
    end else begin
      bus_b.mem_rd = rd; bus_b.mem_wr = wr; bus_b.addr = a; bus_b.wdata = wd;
    end
  endtask

  function automatic logic get_stall(input int sel);
    return (sel == 0) ? bus_a.stall : bus_b.stall;
  endfunction
  function automatic logic get_dv(input int sel);
    return (sel == 0) ? bus_a.data_valid : bus_b.data_valid;
  endfunction
  function automatic logic [15:0] get_rdata(input int sel);
    return (sel == 0) ? bus_a.rdata : bus_b.rdata;
  endfunction

  // Holds the request from one negedge until DONE; counts stalled cycles and
  // records the cycle (1 = acceptance cycle) in which data_valid is seen.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] wd,
                        input int chg_cyc, input logic [15:0] chg_a,
                        output int n_stall, output int dv_cyc, output logic [15:0] rd_at_dv);
    n_stall  = 0;
    dv_cyc   = 0;
    rd_at_dv = '0;
    @(negedge clk);
    drive(sel, rd, wr, a, wd);
    for (int c = 1; c <= 20; c++) begin
      if (c == chg_cyc) drive(sel, rd, wr, chg_a, wd);
      #1;
      if (get_stall(sel)) n_stall++;
      if (get_dv(sel)) begin
        dv_cyc   = c;
        rd_at_dv = get_rdata(sel);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  int          ns, dc;
  logic [15:0] rv;
  logic        dv_seen;

  initial begin
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("rst_rdata", 32'(bus_a.rdata), 32'h0);
    chk("rst_dv", 32'(bus_a.data_valid), 32'h0);
    chk("rst_stall", 32'(bus_a.stall), 32'h0);
    chk("rst_perr", 32'(bus_a.proto_err), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write BEEF to 0x0010: rdata untouched by a write
    access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, 16'h0, ns, dc, rv);
    chk("wr10_stall", 32'(ns), 32'd4);
    chk("wr10_dvcyc", 32'(dc), 32'd5);
    chk("wr10_rdata", 32'(rv), 32'h0);

    access(0, 1'b1, 1'b0, 16'h0010, 16'h0, 0, 16'h0, ns, dc, rv);
    chk("rd10_stall", 32'(ns), 32'd4);
    chk("rd10_dvcyc", 32'(dc), 32'd5);
    chk("rd10_rdata", 32'(rv), 32'hBEEF);
    #1;
    chk("rd10_hold", 32'(bus_a.rdata), 32'hBEEF);

    access(0, 1'b0, 1'b1, 16'h0030, 16'h5555, 0, 16'h0, ns, dc, rv);
    access(0, 1'b0, 1'b1, 16'h0012, 16'h7777, 0, 16'h0, ns, dc, rv);

    // SW style: both strobes high, write wins
    access(0, 1'b1, 1'b1, 16'h0020, 16'h1234, 0, 16'h0, ns, dc, rv);
    chk("sw20_dvcyc", 32'(dc), 32'd5);
    chk("sw20_rdata", 32'(rv), 32'hBEEF);
    access(0, 1'b1, 1'b0, 16'h0020, 16'h0, 0, 16'h0, ns, dc, rv);
    chk("rd20_rdata", 32'(rv), 32'h1234);
    chk("perr_clean", 32'(bus_a.proto_err), 32'h0);

    // Address changes during WAIT: access still targets 0x0010
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0, 2, 16'h0012, ns, dc, rv);
    chk("perr_rdata", 32'(rv), 32'hBEEF);
    chk("perr_set", 32'(bus_a.proto_err), 32'h1);
    access(0, 1'b1, 1'b0, 16'h0020, 16'h0, 0, 16'h0, ns, dc, rv);
    chk("perr_sticky", 32'(bus_a.proto_err), 32'h1);

    // Reset in WAIT of a write: nothing commits, outputs clear asynchronously
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
    @(negedge clk);
    #3;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("arst_rdata", 32'(bus_a.rdata), 32'h0);
    chk("arst_stall", 32'(bus_a.stall), 32'h0);
    chk("arst_dv", 32'(bus_a.data_valid), 32'h0);
    chk("arst_perr", 32'(bus_a.proto_err), 32'h0);
    dv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      #1;
      dv_seen = dv_seen | bus_a.data_valid;
    end
    chk("arst_no_dv", 32'(dv_seen), 32'h0);
    access(0, 1'b1, 1'b0, 16'h0030, 16'h0, 0, 16'h0, ns, dc, rv);
    chk("rd30_old", 32'(rv), 32'h5555);

    // LATENCY=1 with aliasing: 0x0802 and 0x0002 are the same word
    access(1, 1'b0, 1'b1, 16'h0802, 16'hCAFE, 0, 16'h0, ns, dc, rv);
    chk("l1_wr_stall", 32'(ns), 32'd1);
    chk("l1_wr_dvcyc", 32'(dc), 32'd2);
    access(1, 1'b1, 1'b0, 16'h0002, 16'h0, 0, 16'h0, ns, dc, rv);
    chk("l1_rd_stall", 32'(ns), 32'd1);
    chk("l1_rd_dvcyc", 32'(dc), 32'd2);
    chk("l1_rd_alias", 32'(rv), 32'hCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
